// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: scan counters, frame strobe, and sync/blank
// realignment of the returned pixel colour onto the DAC outputs.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGB_in,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        hsync,
    output logic        vsync,
    output logic        blankN,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

    logic [10:0] h_count;
    logic [10:0] v_count;
    logic        active_raw;
    logic        hs_raw;
    logic        vs_raw;
    logic        act_tap;

    logic [PIPE_DELAY:0] hs_dly;
    logic [PIPE_DELAY:0] vs_dly;
    logic [PIPE_DELAY:0] act_dly;

    // Stage p0: raster counters
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? 11'd0 : v_count + 11'd1;
        end else begin
            h_count <= h_count + 11'd1;
        end
    end

    assign pixelX = h_count;
    assign pixelY = v_count;

    always_comb begin
        active_raw = (h_count < H_ACT) && (v_count < V_ACT);
        hs_raw     = !((h_count >= HS_START) && (h_count < HS_END));
        vs_raw     = !((v_count >= VS_START) && (v_count < VS_END));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            startOfFrame <= 1'b0;
        end else begin
            startOfFrame <= (h_count == 11'd0) && (v_count == V_ACT);
        end
    end

    // Stages p1..pN: timing delay line, reset to inactive so no sync glitches while refilling
    if (PIPE_DELAY == 0) begin : g_single
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                hs_dly  <= '1;
                vs_dly  <= '1;
                act_dly <= '0;
            end else begin
                hs_dly  <= hs_raw;
                vs_dly  <= vs_raw;
                act_dly <= active_raw;
            end
        end
        assign act_tap = active_raw;
    end else begin : g_multi
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                hs_dly  <= '1;
                vs_dly  <= '1;
                act_dly <= '0;
            end else begin
                hs_dly  <= {hs_dly[PIPE_DELAY-1:0], hs_raw};
                vs_dly  <= {vs_dly[PIPE_DELAY-1:0], vs_raw};
                act_dly <= {act_dly[PIPE_DELAY-1:0], active_raw};
            end
        end
        assign act_tap = act_dly[PIPE_DELAY-1];
    end

    // Final stage: colour register, lands together with the last delay-line tap
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (act_tap) begin
            red   <= expand3(RGB_in[7:5]);
            green <= expand3(RGB_in[4:2]);
            blue  <= expand2(RGB_in[1:0]);
        end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end
    end

    assign hsync  = hs_dly[PIPE_DELAY];
    assign vsync  = vs_dly[PIPE_DELAY];
    assign blankN = act_dly[PIPE_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing with a one-clock pipeline, plus a reduced
// raster with a three-clock pipeline for frame, wrap and mid-frame reset cases.
module tb_vga_timing_gen;

    localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HBP = 3;
    localparam int S_VA = 4, S_VFP = 1, S_VS = 2, S_VBP = 2;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam int SP   = 3;
    localparam int HIT_X = 5, HIT_Y = 2;

    logic        clk;
    logic        rst_n_d, rst_n_s;
    logic [7:0]  rgb_d, rgb_s;
    logic [10:0] pixelX_d, pixelY_d, pixelX_s, pixelY_s;
    logic        sof_d, hsync_d, vsync_d, blankN_d;
    logic        sof_s, hsync_s, vsync_s, blankN_s;
    logic [7:0]  red_d, green_d, blue_d, red_s, green_s, blue_s;

    vga_timing_gen dut_d (
        .clk(clk), .resetN(rst_n_d), .RGB_in(rgb_d),
        .pixelX(pixelX_d), .pixelY(pixelY_d), .startOfFrame(sof_d),
        .hsync(hsync_d), .vsync(vsync_d), .blankN(blankN_d),
        .red(red_d), .green(green_d), .blue(blue_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .PIPE_DELAY(SP)
    ) dut_s (
        .clk(clk), .resetN(rst_n_s), .RGB_in(rgb_s),
        .pixelX(pixelX_s), .pixelY(pixelY_s), .startOfFrame(sof_s),
        .hsync(hsync_s), .vsync(vsync_s), .blankN(blankN_s),
        .red(red_s), .green(green_s), .blue(blue_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    endtask

    typedef struct {
        logic [7:0] rgb;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;
    vec_t vecs[6];

    // reduced-raster reference state
    int mx, my, sof_cnt, hit_cnt;
    int hx[8], hy[8];
    bit hv[8];

    task automatic sb_step();
        int x, y;
        logic ehs, evs, eact, esof;
        logic [7:0] ergb;
        @(negedge clk);
        for (int k = 7; k > 0; k--) begin
            hx[k] = hx[k-1]; hy[k] = hy[k-1]; hv[k] = hv[k-1];
        end
        hx[0] = mx; hy[0] = my; hv[0] = 1'b1;
        chk("s_pixelX", 32'(pixelX_s), 32'(mx));
        chk("s_pixelY", 32'(pixelY_s), 32'(my));
        ehs = 1'b1; evs = 1'b1; eact = 1'b0; ergb = 8'h00;
        if (hv[SP+1]) begin
            x = hx[SP+1]; y = hy[SP+1];
            ehs  = !(x >= S_HA + S_HFP && x < S_HA + S_HFP + S_HS);
            evs  = !(y >= S_VA + S_VFP && y < S_VA + S_VFP + S_VS);
            eact = (x < S_HA) && (y < S_VA);
            ergb = (eact && x == HIT_X && y == HIT_Y) ? 8'hFF : 8'h00;
        end
        chk("s_hsync", 32'(hsync_s), 32'(ehs));
        chk("s_vsync", 32'(vsync_s), 32'(evs));
        chk("s_blankN", 32'(blankN_s), 32'(eact));
        chk("s_red", 32'(red_s), 32'(ergb));
        chk("s_green", 32'(green_s), 32'(ergb));
        chk("s_blue", 32'(blue_s), 32'(ergb));
        esof = hv[1] && hx[1] == 0 && hy[1] == S_VA;
        chk("s_sof", 32'(sof_s), 32'(esof));
        if (sof_s) sof_cnt++;
        if (red_s == 8'hFF) hit_cnt++;
        rgb_s = (hv[SP] && hx[SP] == HIT_X && hy[SP] == HIT_Y) ? 8'hFF : 8'h00;
        mx++;
        if (mx == S_HT) begin
            mx = 0;
            my++;
            if (my == S_VT) my = 0;
        end
    endtask

    initial begin
        int x, y;
        logic ehs, evs, eact;
        clk = 0;
        rst_n_d = 0;
        rst_n_s = 0;
        rgb_d = 8'b111_000_11;
        rgb_s = 8'h00;
        vecs[0] = '{8'hFF,         8'hFF, 8'hFF, 8'hFF};
        vecs[1] = '{8'h00,         8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'b111_000_11, 8'hFF, 8'h00, 8'hFF};
        vecs[3] = '{8'b100_010_01, 8'h92, 8'h49, 8'h55};
        vecs[4] = '{8'b011_101_10, 8'h6D, 8'hB6, 8'hAA};
        vecs[5] = '{8'b001_110_00, 8'h24, 8'hDB, 8'h00};
        mx = 0; my = 0; sof_cnt = 0; hit_cnt = 0;
        for (int k = 0; k < 8; k++) begin hx[k] = 0; hy[k] = 0; hv[k] = 1'b0; end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pixelX", 32'(pixelX_d), 32'd0);
        chk("rst_pixelY", 32'(pixelY_d), 32'd0);
        chk("rst_hsync", 32'(hsync_d), 32'd1);
        chk("rst_vsync", 32'(vsync_d), 32'd1);
        chk("rst_blankN", 32'(blankN_d), 32'd0);
        chk("rst_red", 32'(red_d), 32'd0);
        chk("rst_blue", 32'(blue_d), 32'd0);
        chk("rst_sof", 32'(sof_d), 32'd0);
        chk("rst_s_hsync", 32'(hsync_s), 32'd1);
        chk("rst_s_blankN", 32'(blankN_s), 32'd0);

        // full-size raster, constant colour, first two lines
        @(posedge clk);
        #2 rst_n_d = 1;
        for (int t = 0; t < 1650; t++) begin
            @(negedge clk);
            if (t < 2) begin
                ehs = 1'b1; evs = 1'b1; eact = 1'b0;
            end else begin
                x = (t - 2) % 800;
                y = (t - 2) / 800;
                ehs  = !(x >= 656 && x < 752);
                evs  = !(y >= 490 && y < 492);
                eact = (x < 640) && (y < 480);
            end
            chk("d_pixelX", 32'(pixelX_d), 32'(t % 800));
            chk("d_pixelY", 32'(pixelY_d), 32'(t / 800));
            chk("d_hsync", 32'(hsync_d), 32'(ehs));
            chk("d_vsync", 32'(vsync_d), 32'(evs));
            chk("d_blankN", 32'(blankN_d), 32'(eact));
            chk("d_red", 32'(red_d), eact ? 32'hFF : 32'h0);
            chk("d_green", 32'(green_d), 32'h0);
            chk("d_blue", 32'(blue_d), eact ? 32'hFF : 32'h0);
            chk("d_sof", 32'(sof_d), 32'd0);
        end

        // colour expansion table, inside the visible part of line 2
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rgb_d = vecs[i].rgb;
            @(negedge clk);
            chk("vec_blankN", 32'(blankN_d), 32'd1);
            chk("vec_red", 32'(red_d), 32'(vecs[i].r));
            chk("vec_green", 32'(green_d), 32'(vecs[i].g));
            chk("vec_blue", 32'(blue_d), 32'(vecs[i].b));
        end

        // reduced raster, deep pipeline: two full frames then into the third
        @(posedge clk);
        #2 rst_n_s = 1;
        for (int i = 0; i < 348; i++) begin
            sb_step();
            if (i == 287) begin
                chk("s_sof_count", 32'(sof_cnt), 32'd2);
                chk("s_hit_count", 32'(hit_cnt), 32'd2);
            end
        end

        // asynchronous reset while counters read (11,3)
        #2 rst_n_s = 0;
        #1;
        chk("arst_pixelX", 32'(pixelX_s), 32'd0);
        chk("arst_pixelY", 32'(pixelY_s), 32'd0);
        chk("arst_hsync", 32'(hsync_s), 32'd1);
        chk("arst_vsync", 32'(vsync_s), 32'd1);
        chk("arst_blankN", 32'(blankN_s), 32'd0);
        chk("arst_red", 32'(red_s), 32'd0);
        chk("arst_sof", 32'(sof_s), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n_s = 1;
        rgb_s = 8'h00;
        mx = 0; my = 0;
        for (int k = 0; k < 8; k++) hv[k] = 1'b0;
        for (int i = 0; i < 160; i++) sb_step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
